// File: rtl/snack_catalog_pkg.sv
// Shared types and helpers for the snack catalogue: FSM states, keypad digit width,
// and the keypad-code-to-slot mapping.
package snack_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT1,
    ST_GOT2,
    ST_LOOKUP,
    ST_SHOW,
    ST_ERR
  } state_t;

  // Row and column are decimal digits, so the result never exceeds 99.
  function automatic logic [6:0] code_to_slot(input logic [DIGIT_W-1:0] r,
                                              input logic [DIGIT_W-1:0] c);
    return 7'(r) * 7'd10 + 7'(c);
  endfunction

  function automatic logic code_valid(input logic [6:0] slot, input int num_slots);
    return {25'd0, slot} < num_slots[31:0];
  endfunction

endpackage

// File: rtl/snack_catalog_if.sv
// Bus between the keypad/payment logic (master) and the catalogue (slave).
// The low_stock signal exists only when SNACK_CATALOG_LOWSTOCK_EN is defined.
interface snack_catalog_if
  import snack_pkg::*;
#(
  parameter int NUM_SLOTS = 40,
  parameter int PRICE_W   = 10,
  parameter int CNT_W     = 4
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                 digit_valid;
  logic [DIGIT_W-1:0]   digit;
  logic                 clear;
  logic                 cfg_we;
  logic [SLOT_W-1:0]    cfg_slot;
  logic [PRICE_W-1:0]   cfg_price;
  logic [CNT_W-1:0]     cfg_count;
  logic                 vend_req;
  logic                 vend_ack;
  logic                 sel_valid;
  logic [SLOT_W-1:0]    sel_slot;
  logic [PRICE_W-1:0]   snack_price;
  logic                 in_stock;
  logic                 sel_err;
  logic [NUM_SLOTS-1:0] curr_inv;
`ifdef SNACK_CATALOG_LOWSTOCK_EN
  logic [NUM_SLOTS-1:0] low_stock;
`endif

  modport master (
    output digit_valid, digit, clear, cfg_we, cfg_slot, cfg_price, cfg_count, vend_req,
    input  vend_ack, sel_valid, sel_slot, snack_price, in_stock, sel_err, curr_inv
`ifdef SNACK_CATALOG_LOWSTOCK_EN
    , low_stock
`endif
  );

  modport slave (
    input  digit_valid, digit, clear, cfg_we, cfg_slot, cfg_price, cfg_count, vend_req,
    output vend_ack, sel_valid, sel_slot, snack_price, in_stock, sel_err, curr_inv
`ifdef SNACK_CATALOG_LOWSTOCK_EN
    , low_stock
`endif
  );

endinterface

// File: rtl/snack_catalog_slot_store.sv
// Per-slot price and stock registers with a config write port that overrides a
// same-cycle decrement. Optional low_stock vector under SNACK_CATALOG_LOWSTOCK_EN.
module slot_store
  import snack_pkg::*;
#(
  parameter int NUM_SLOTS  = 40,
  parameter int PRICE_W    = 10,
  parameter int CNT_W      = 4,
  parameter int LOW_THRESH = 2,
  parameter int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we_i,
  input  logic [SLOT_W-1:0]    cfg_slot_i,
  input  logic [PRICE_W-1:0]   cfg_price_i,
  input  logic [CNT_W-1:0]     cfg_count_i,
  input  logic                 dec_en_i,
  input  logic [SLOT_W-1:0]    dec_slot_i,
  input  logic [SLOT_W-1:0]    rd_slot_i,
  output logic [PRICE_W-1:0]   rd_price_o,
  output logic                 rd_nz_o,
  output logic [NUM_SLOTS-1:0] curr_inv_o
`ifdef SNACK_CATALOG_LOWSTOCK_EN
  ,
  output logic [NUM_SLOTS-1:0] low_stock_o
`endif
);

  logic [PRICE_W-1:0] price_arr [NUM_SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [PRICE_W-1:0] price_q, price_d;
      logic [CNT_W-1:0]   count_q, count_d;
      logic               cfg_hit, dec_hit;

      // Out-of-range cfg_slot values match no slot and are dropped naturally.
      assign cfg_hit = cfg_we_i && (cfg_slot_i == SLOT_W'(gi));
      assign dec_hit = dec_en_i && (dec_slot_i == SLOT_W'(gi)) && (count_q != '0);

      always_comb begin
        price_d = price_q;
        count_d = count_q;
        if (cfg_hit) begin
          price_d = cfg_price_i;
          count_d = cfg_count_i;
        end else if (dec_hit) begin
          count_d = count_q - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          price_q <= '0;
          count_q <= '0;
        end else begin
          price_q <= price_d;
          count_q <= count_d;
        end
      end

      assign price_arr[gi]  = price_q;
      assign curr_inv_o[gi] = (count_q != '0);

`ifdef SNACK_CATALOG_LOWSTOCK_EN
      logic low_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) low_q <= 1'b0;
        else        low_q <= (count_d != '0) && (count_d <= CNT_W'(LOW_THRESH));
      end
      assign low_stock_o[gi] = low_q;
`endif
    end
  endgenerate

  assign rd_price_o = price_arr[rd_slot_i];
  assign rd_nz_o    = curr_inv_o[rd_slot_i];

endmodule

// File: rtl/snack_catalog.sv
// Keypad entry FSM, vend handshake and slot store for the vending catalogue.
// Define SNACK_CATALOG_LOWSTOCK_EN to add the low_stock output.
module snack_catalog
  import snack_pkg::*;
#(
  parameter int NUM_SLOTS  = 40,
  parameter int PRICE_W    = 10,
  parameter int CNT_W      = 4,
  parameter int LOW_THRESH = 2
)(
  input  logic           clk,
  input  logic           rst_n,
  snack_catalog_if.slave bus
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] row_q, row_d, col_q, col_d;
  logic [SLOT_W-1:0]  sel_slot_q, sel_slot_d;
  logic               vend_ack_q, vend_ack_d;
  logic               vend_err_q, vend_err_d;

  logic               digit_ok, code_ok, dec_en, show;
  logic [6:0]         code_slot;
  logic [PRICE_W-1:0] rd_price;
  logic               rd_nz;

  assign digit_ok  = bus.digit_valid && (bus.digit <= DIGIT_W'(9));
  assign code_slot = code_to_slot(row_q, col_q);
  assign code_ok   = code_valid(code_slot, NUM_SLOTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      sel_slot_q <= '0;
      vend_ack_q <= 1'b0;
      vend_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sel_slot_q <= sel_slot_d;
      vend_ack_q <= vend_ack_d;
      vend_err_q <= vend_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    sel_slot_d = sel_slot_q;
    unique case (state_q)
      ST_IDLE: if (digit_ok) state_d = (bus.digit == DIGIT_W'(1)) ? ST_GOT1 : ST_ERR;
      ST_GOT1: if (digit_ok) begin
        row_d   = bus.digit;
        state_d = ST_GOT2;
      end
      ST_GOT2: if (digit_ok) begin
        col_d   = bus.digit;
        state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (code_ok) begin
          sel_slot_d = SLOT_W'(code_slot);
          state_d    = ST_SHOW;
        end else begin
          state_d = ST_ERR;
        end
      end
      // A vend request outranks a fresh digit arriving in the same cycle.
      ST_SHOW: begin
        if (bus.vend_req)  state_d = ST_IDLE;
        else if (digit_ok) state_d = (bus.digit == DIGIT_W'(1)) ? ST_GOT1 : ST_ERR;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.clear) state_d = ST_IDLE;
  end

  always_comb begin
    show            = (state_q == ST_SHOW);
    dec_en          = show && bus.vend_req && !bus.clear && rd_nz;
    vend_ack_d      = dec_en;
    vend_err_d      = show && bus.vend_req && !bus.clear && !rd_nz;
    bus.sel_valid   = show;
    bus.sel_slot    = show ? sel_slot_q : '0;
    bus.snack_price = show ? rd_price : '0;
    bus.in_stock    = show && rd_nz;
    bus.sel_err     = (state_q == ST_ERR) || vend_err_q;
    bus.vend_ack    = vend_ack_q;
  end

  slot_store #(
    .NUM_SLOTS (NUM_SLOTS),
    .PRICE_W   (PRICE_W),
    .CNT_W     (CNT_W),
    .LOW_THRESH(LOW_THRESH),
    .SLOT_W    (SLOT_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we_i   (bus.cfg_we),
    .cfg_slot_i (bus.cfg_slot),
    .cfg_price_i(bus.cfg_price),
    .cfg_count_i(bus.cfg_count),
    .dec_en_i   (dec_en),
    .dec_slot_i (sel_slot_q),
    .rd_slot_i  (sel_slot_q),
    .rd_price_o (rd_price),
    .rd_nz_o    (rd_nz),
    .curr_inv_o (bus.curr_inv)
`ifdef SNACK_CATALOG_LOWSTOCK_EN
    ,
    .low_stock_o(bus.low_stock)
`endif
  );

endmodule

// File: tb/tb_snack_catalog.sv
// Randomised self-checking bench for snack_catalog against an array-based catalogue model.
module tb_snack_catalog;
  import snack_pkg::*;

  localparam int NS = 40;
  localparam int PW = 10;
  localparam int CW = 4;
  localparam int LT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snack_catalog_if #(.NUM_SLOTS(NS), .PRICE_W(PW), .CNT_W(CW)) bus ();

  snack_catalog #(.NUM_SLOTS(NS), .PRICE_W(PW), .CNT_W(CW), .LOW_THRESH(LT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int m_price [NS];
  int m_count [NS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_inv();
    logic [63:0] v = '0;
    for (int i = 0; i < NS; i++) v[i] = (m_count[i] != 0);
    return v;
  endfunction

  function automatic logic [63:0] model_low();
    logic [63:0] v = '0;
    for (int i = 0; i < NS; i++) v[i] = (m_count[i] != 0) && (m_count[i] <= LT);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_inv(input string tag);
    chk({tag, ".inv"}, 64'(bus.curr_inv), model_inv());
`ifdef SNACK_CATALOG_LOWSTOCK_EN
    chk({tag, ".low"}, 64'(bus.low_stock), model_low());
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_price[i] = 0;
      m_count[i] = 0;
    end
  endtask

  task automatic key(input int d);
    bus.digit_valid = 1'b1;
    bus.digit       = 4'(d);
    step();
    bus.digit_valid = 1'b0;
  endtask

  task automatic cfg(input int slot, input int price, input int count);
    bus.cfg_we    = 1'b1;
    bus.cfg_slot  = 6'(slot);
    bus.cfg_price = 10'(price);
    bus.cfg_count = 4'(count);
    step();
    bus.cfg_we = 1'b0;
    if (slot < NS) begin
      m_price[slot] = price;
      m_count[slot] = count;
    end
    $display("txn cfg slot=%0d price=%0d count=%0d", slot, price, count);
    check_inv("cfg");
  endtask

  // Keys 1,r,c and checks either the shown selection or the error pulse.
  task automatic enter(input int r, input int c, output bit shown);
    int slot = 10 * r + c;
    key(1);
    key(r);
    key(c);
    chk("lookup.valid", 64'(bus.sel_valid), 64'd0);
    step();
    $display("txn key 1%0d%0d slot=%0d", r, c, slot);
    if (slot < NS) begin
      chk("show.valid", 64'(bus.sel_valid), 64'd1);
      chk("show.slot", 64'(bus.sel_slot), 64'(slot));
      chk("show.price", 64'(bus.snack_price), 64'(m_price[slot]));
      chk("show.stock", 64'(bus.in_stock), 64'(m_count[slot] != 0));
      chk("show.err", 64'(bus.sel_err), 64'd0);
      shown = 1'b1;
    end else begin
      chk("badcode.err", 64'(bus.sel_err), 64'd1);
      chk("badcode.valid", 64'(bus.sel_valid), 64'd0);
      step();
      chk("badcode.err_end", 64'(bus.sel_err), 64'd0);
      shown = 1'b0;
    end
  endtask

  task automatic vend(input int slot);
    bit ok = (m_count[slot] != 0);
    bus.vend_req = 1'b1;
    step();
    bus.vend_req = 1'b0;
    if (ok) m_count[slot]--;
    $display("txn vend slot=%0d ok=%0d", slot, ok);
    chk("vend.ack", 64'(bus.vend_ack), 64'(ok));
    chk("vend.err", 64'(bus.sel_err), 64'(!ok));
    chk("vend.idle", 64'(bus.sel_valid), 64'd0);
    check_inv("vend");
    step();
    chk("vend.ack_end", 64'(bus.vend_ack), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 64'(bus.sel_valid), 64'd0);
    chk({tag, ".slot"}, 64'(bus.sel_slot), 64'd0);
    chk({tag, ".price"}, 64'(bus.snack_price), 64'd0);
    chk({tag, ".stock"}, 64'(bus.in_stock), 64'd0);
    chk({tag, ".err"}, 64'(bus.sel_err), 64'd0);
    chk({tag, ".ack"}, 64'(bus.vend_ack), 64'd0);
    check_inv(tag);
  endtask

  initial begin
    bit shown;
    bus.digit_valid = 1'b0;
    bus.digit       = '0;
    bus.clear       = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_slot    = '0;
    bus.cfg_price   = '0;
    bus.cfg_count   = '0;
    bus.vend_req    = 1'b0;
    model_clear();

    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();
    check_zero("post_reset");

    // Slot 12 stocked with three: three good vends, then an out-of-stock vend.
    cfg(12, 125, 3);
    for (int k = 0; k < 4; k++) begin
      enter(1, 2, shown);
      vend(12);
    end
    chk("slot12.empty", 64'(bus.curr_inv[12]), 64'd0);

    key(2);
    $display("txn key 2");
    chk("bad_first.err", 64'(bus.sel_err), 64'd1);
    chk("bad_first.valid", 64'(bus.sel_valid), 64'd0);
    step();
    chk("bad_first.err_end", 64'(bus.sel_err), 64'd0);
    enter(9, 9, shown);

    // Config write and vend on the same slot in the same cycle: config wins, ack still given.
    cfg(5, 50, 1);
    enter(0, 5, shown);
    bus.vend_req  = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_slot  = 6'd5;
    bus.cfg_price = 10'd60;
    bus.cfg_count = 4'd7;
    step();
    bus.vend_req = 1'b0;
    bus.cfg_we   = 1'b0;
    m_price[5]   = 60;
    m_count[5]   = 7;
    $display("txn vend+cfg slot=5");
    chk("vcfg.ack", 64'(bus.vend_ack), 64'd1);
    check_inv("vcfg");
    step();
    enter(0, 5, shown);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;

    // Clear after two digits: the following 1,0,5 must resolve to slot 5.
    key(1);
    key(4);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    $display("txn clear");
    chk("clear.valid", 64'(bus.sel_valid), 64'd0);
    enter(0, 5, shown);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;

    // Digits above 9 are ignored mid-entry.
    key(1);
    key(12);
    key(1);
    key(2);
    step();
    $display("txn key 1,12,1,2");
    chk("bigdigit.valid", 64'(bus.sel_valid), 64'd1);
    chk("bigdigit.slot", 64'(bus.sel_slot), 64'd12);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;

    // Low-stock walk on slot 20.
    cfg(20, 200, 3);
    for (int k = 0; k < 3; k++) begin
      enter(2, 0, shown);
      vend(20);
    end

    for (int it = 0; it < 80; it++) begin
      int act = $urandom_range(0, 9);
      if (act < 3) begin
        cfg($urandom_range(0, 47), $urandom_range(0, 1023), $urandom_range(0, 15));
      end else if (act == 3) begin
        int d = $urandom_range(0, 9);
        if (d == 1) d = 0;
        key(d);
        $display("txn key %0d", d);
        chk("rnd_first.err", 64'(bus.sel_err), 64'd1);
        step();
        chk("rnd_first.err_end", 64'(bus.sel_err), 64'd0);
      end else begin
        int r = $urandom_range(0, 4);
        int c = $urandom_range(0, 9);
        int slot = 10 * r + c;
        enter(r, c, shown);
        if (shown) begin
          if ($urandom_range(0, 9) < 3) begin
            cfg(slot, $urandom_range(0, 1023), $urandom_range(0, 3));
            chk("live.price", 64'(bus.snack_price), 64'(m_price[slot]));
            chk("live.stock", 64'(bus.in_stock), 64'(m_count[slot] != 0));
            chk("live.valid", 64'(bus.sel_valid), 64'd1);
          end
          if ($urandom_range(0, 9) < 7) begin
            vend(slot);
          end else begin
            bus.clear = 1'b1;
            step();
            bus.clear = 1'b0;
            $display("txn clear");
            chk("rnd_clear.valid", 64'(bus.sel_valid), 64'd0);
          end
        end
      end
    end

    // Reset mid-entry wipes the store and all outputs at once.
    key(1);
    key(4);
    rst_n = 1'b0;
    #1;
    model_clear();
    $display("txn reset");
    check_zero("midreset");
    step();
    rst_n = 1'b1;
    step();
    check_zero("after_midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
